icache_req_arbiter: RTL and testbench
=====================================

// Module: icache_req_arbiter
// PURPOSE
// - Shares the single blocking ICache request port between the IFU demand fetch and the next-line prefetcher.
// - Sits between the IFU/prefetcher and the ICache. Tracks the one outstanding request and routes its response to the owner.
// - Folds a demand fetch into an in-flight prefetch of the same line (merge), and drops prefetches of the last demand line.
// - On backend flush, drains the in-flight response and discards it.
// PARAMETERS
// - VLEN        default 32   virtual address width
// - FETCH_W     default 128  response data width (INSTR_PER_FETCH*ILEN)
// - LINE_BYTES  default 64   ICache line size; line tag = addr[VLEN-1:$clog2(LINE_BYTES)]
// PORTS
// - clk             in   1        clock
// - rst             in   1        synchronous, active-high reset
// - flush_i         in   1        backend flush/redirect pulse
// - dmd_req_valid_i in   1        IFU demand request valid
// - dmd_req_ready_o out  1        demand request accepted (issued or merged)
// - dmd_req_addr_i  in   VLEN     demand fetch address
// - pf_req_valid_i  in   1        prefetch request valid
// - pf_req_ready_o  out  1        prefetch request accepted (issued or dropped)
// - pf_req_addr_i   in   VLEN     prefetch line address
// - ic_req_valid_o  out  1        ICache request valid
// - ic_req_ready_i  in   1        ICache can accept a request
// - ic_req_addr_o   out  VLEN     ICache request address
// - ic_rsp_valid_i  in   1        ICache response valid (one-cycle pulse, no backpressure)
// - ic_rsp_data_i   in   FETCH_W  ICache response data
// - dmd_rsp_valid_o out  1        response for demand (one-cycle pulse)
// - dmd_rsp_addr_o  out  VLEN     demand address the response belongs to
// - dmd_rsp_data_o  out  FETCH_W  = ic_rsp_data_i
// - pf_rsp_valid_o  out  1        prefetch completion pulse
// - busy_o          out  1        state != IDLE
// BEHAVIOUR
// - State machine
//   - States: IDLE, WAIT_RSP, DRAIN.
//   - Reset: state=IDLE; owner, merged, last_dmd_line_vld and all latches cleared.
//   - All outputs are combinational from state and inputs, so every valid/ready output is 0 while inputs are low.
// - IDLE, arbitration
//   - Demand has fixed priority. Prefetch is selected only when dmd_req_valid_i=0.
//   - ic_req_valid_o = selected valid & !flush_i.
//   - ic_req_addr_o = selected address.
//   - Selected ready = ic_req_ready_i & !flush_i.
// - IDLE, request fire
//   - Fire = valid & ready. Latch owner (DMD/PF) and addr, then go to WAIT_RSP next cycle.
//   - Issue latency is 0 cycles (same-cycle pass-through).
// - IDLE, prefetch drop
//   - Condition: selected prefetch has line tag == last_dmd_line_q and last_dmd_line_vld.
//   - Drive pf_req_ready_o=1, ic_req_valid_o=0, and stay in IDLE. No pf_rsp pulse.
// - WAIT_RSP, response
//   - On ic_rsp_valid_i: route to owner, then go to IDLE next cycle.
//   - Owner DMD: dmd_rsp_valid_o=1, dmd_rsp_addr_o=latched addr, and set last_dmd_line_q.
//   - Owner PF: pf_rsp_valid_o=1. If merged, also dmd_rsp_valid_o=1 with dmd_rsp_addr_o=merged addr.
// - WAIT_RSP, merge
//   - Condition: owner=PF, !merged, dmd_req_valid_i, line(dmd addr)==line(latched addr), !ic_rsp_valid_i, !flush_i.
//   - Action: dmd_req_ready_o=1; set merged and latch the demand address.
//   - A merge is never accepted in the response cycle; that demand waits for IDLE.
// - WAIT_RSP, other
//   - ic_req_valid_o=0.
//   - All request readys are 0 except the merge case above.
// - Flush
//   - flush_i suppresses every req ready/valid and every rsp valid in its cycle.
//   - Flush in IDLE: stay IDLE.
//   - Flush in WAIT_RSP without rsp: go to DRAIN.
//   - Flush in WAIT_RSP with rsp: drop the response, go to IDLE.
//   - Flush clears merged and last_dmd_line_vld.
// - DRAIN
//   - No request is issued and no response is forwarded.
//   - On ic_rsp_valid_i: go to IDLE. A repeated flush_i keeps the block in DRAIN.
// - Reset mid-operation: return to IDLE. The ICache is reset in the same cycle, so no stale response can arrive.
// - Width rules: line compare is an unsigned equality on the upper VLEN-$clog2(LINE_BYTES) bits. No arithmetic on addresses.
// STRUCTURE
// - Place in global_config_pkg:
//   - typedef enum logic[1:0] {ARB_IDLE, ARB_WAIT_RSP, ARB_DRAIN} icache_arb_state_e;
//   - typedef enum logic {OWN_DMD, OWN_PF} icache_arb_owner_e;
// - Single flat module; no sub-module (one FSM plus a line-compare function).
// TESTING (LINE_BYTES=64, ic_req_ready_i=1 unless stated)
// - Demand 0x8000_0000, rsp 3 cyc later, data 0xDEAD -> same-cycle ic_req_addr_o=0x80000000; dmd_rsp_valid_o pulse, addr 0x80000000, pf_rsp_valid_o=0.
// - Dmd 0x80000040 and pf 0x80000080 valid together -> demand issued first. Prefetch issued in the IDLE cycle after the demand rsp; pf_rsp_valid_o on its rsp.
// - Pf 0x80000100 in flight, dmd 0x80000108 valid -> dmd_req_ready_o=1, no ic_req. On rsp: dmd_rsp_valid_o=pf_rsp_valid_o=1, dmd_rsp_addr_o=0x80000108.
// - Demand 0x80000200 completes, then pf 0x80000220 -> pf_req_ready_o=1, ic_req_valid_o=0, state stays IDLE.
// - Flush in WAIT_RSP, rsp 2 cyc later -> no rsp valid. dmd 0x90000000 held until the drain cycle, issued the cycle after.
// - Flush coincident with rsp in WAIT_RSP -> no rsp valid, busy_o=0 next cycle, and the pending demand issues that cycle.

Source files
------------

// File: rtl/global_config_pkg.sv
// Shared enums for the ICache request arbiter.
package global_config_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_RSP, ARB_DRAIN} icache_arb_state_e;
  typedef enum logic {OWN_DMD, OWN_PF} icache_arb_owner_e;

endpackage

// File: rtl/icache_req_arbiter.sv
// Shares the blocking ICache request port between demand fetch and prefetch.
// The arbiter tracks the single outstanding request, merges demand into a same-line prefetch, and drains the response on flush.
module icache_req_arbiter
  import global_config_pkg::*;
#(
  parameter int VLEN       = 32,
  parameter int FETCH_W    = 128,
  parameter int LINE_BYTES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               dmd_req_valid_i,
  output logic               dmd_req_ready_o,
  input  logic [VLEN-1:0]    dmd_req_addr_i,
  input  logic               pf_req_valid_i,
  output logic               pf_req_ready_o,
  input  logic [VLEN-1:0]    pf_req_addr_i,
  output logic               ic_req_valid_o,
  input  logic               ic_req_ready_i,
  output logic [VLEN-1:0]    ic_req_addr_o,
  input  logic               ic_rsp_valid_i,
  input  logic [FETCH_W-1:0] ic_rsp_data_i,
  output logic               dmd_rsp_valid_o,
  output logic [VLEN-1:0]    dmd_rsp_addr_o,
  output logic [FETCH_W-1:0] dmd_rsp_data_o,
  output logic               pf_rsp_valid_o,
  output logic               busy_o
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int TAG_W = VLEN - OFF;

  function automatic logic same_line(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    return a[VLEN-1:OFF] == b[VLEN-1:OFF];
  endfunction

  icache_arb_state_e state_q, state_d;
  icache_arb_owner_e owner_q, owner_d;
  logic [VLEN-1:0]   addr_q, addr_d;
  logic              merged_q, merged_d;
  logic [VLEN-1:0]   mrg_addr_q, mrg_addr_d;
  logic [TAG_W-1:0]  last_line_q, last_line_d;
  logic              last_vld_q, last_vld_d;
  logic              pf_drop;

  assign busy_o         = (state_q != ARB_IDLE);
  assign dmd_rsp_data_o = ic_rsp_data_i;
  assign ic_req_addr_o  = dmd_req_valid_i ? dmd_req_addr_i : pf_req_addr_i;
  // Prefetch of the line the last demand just brought in is useless; accept and discard it.
  assign pf_drop = !dmd_req_valid_i && pf_req_valid_i && last_vld_q &&
                   (pf_req_addr_i[VLEN-1:OFF] == last_line_q);

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    merged_d        = merged_q;
    mrg_addr_d      = mrg_addr_q;
    last_line_d     = last_line_q;
    last_vld_d      = last_vld_q;
    dmd_req_ready_o = 1'b0;
    pf_req_ready_o  = 1'b0;
    ic_req_valid_o  = 1'b0;
    dmd_rsp_valid_o = 1'b0;
    pf_rsp_valid_o  = 1'b0;
    dmd_rsp_addr_o  = addr_q;

    case (state_q)
      ARB_IDLE: begin
        if (!flush_i) begin
          if (dmd_req_valid_i) begin
            ic_req_valid_o  = 1'b1;
            dmd_req_ready_o = ic_req_ready_i;
            owner_d         = OWN_DMD;
          end else if (pf_drop) begin
            pf_req_ready_o = 1'b1;
          end else if (pf_req_valid_i) begin
            ic_req_valid_o = 1'b1;
            pf_req_ready_o = ic_req_ready_i;
            owner_d        = OWN_PF;
          end
          if (ic_req_valid_o && ic_req_ready_i) begin
            state_d  = ARB_WAIT_RSP;
            addr_d   = ic_req_addr_o;
            merged_d = 1'b0;
          end
        end
      end
      ARB_WAIT_RSP: begin
        if (flush_i) begin
          state_d = ic_rsp_valid_i ? ARB_IDLE : ARB_DRAIN;
        end else if (ic_rsp_valid_i) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_DMD) begin
            dmd_rsp_valid_o = 1'b1;
            last_line_d     = addr_q[VLEN-1:OFF];
            last_vld_d      = 1'b1;
          end else begin
            pf_rsp_valid_o = 1'b1;
            if (merged_q) begin
              dmd_rsp_valid_o = 1'b1;
              dmd_rsp_addr_o  = mrg_addr_q;
            end
          end
        end else if (owner_q == OWN_PF && !merged_q && dmd_req_valid_i &&
                     same_line(dmd_req_addr_i, addr_q)) begin
          dmd_req_ready_o = 1'b1;
          merged_d        = 1'b1;
          mrg_addr_d      = dmd_req_addr_i;
        end
      end
      ARB_DRAIN: begin
        if (!flush_i && ic_rsp_valid_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (flush_i) begin
      merged_d   = 1'b0;
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_DMD;
      addr_q      <= '0;
      merged_q    <= 1'b0;
      mrg_addr_q  <= '0;
      last_line_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      merged_q    <= merged_d;
      mrg_addr_q  <= mrg_addr_d;
      last_line_q <= last_line_d;
      last_vld_q  <= last_vld_d;
    end
  end

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Scoreboard bench for icache_req_arbiter: directed stimulus pushes expected ICache requests and responses,
// negedge monitors pop and compare whenever the DUT presents them.
module tb_icache_req_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         dmd_v = 1'b0, pf_v = 1'b0, rsp_v = 1'b0, ic_rdy = 1'b1;
  logic [31:0]  dmd_a = '0, pf_a = '0;
  logic [127:0] rsp_d = '0;
  logic         dmd_req_ready_o, pf_req_ready_o, ic_req_valid_o;
  logic         dmd_rsp_valid_o, pf_rsp_valid_o, busy_o;
  logic [31:0]  ic_req_addr_o, dmd_rsp_addr_o;
  logic [127:0] dmd_rsp_data_o;

  icache_req_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .dmd_req_valid_i(dmd_v), .dmd_req_ready_o(dmd_req_ready_o), .dmd_req_addr_i(dmd_a),
    .pf_req_valid_i(pf_v), .pf_req_ready_o(pf_req_ready_o), .pf_req_addr_i(pf_a),
    .ic_req_valid_o(ic_req_valid_o), .ic_req_ready_i(ic_rdy), .ic_req_addr_o(ic_req_addr_o),
    .ic_rsp_valid_i(rsp_v), .ic_rsp_data_i(rsp_d),
    .dmd_rsp_valid_o(dmd_rsp_valid_o), .dmd_rsp_addr_o(dmd_rsp_addr_o),
    .dmd_rsp_data_o(dmd_rsp_data_o), .pf_rsp_valid_o(pf_rsp_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         dmd;
    logic         pf;
    logic [31:0]  addr;
    logic [127:0] data;
  } rsp_t;

  logic [31:0] req_q[$];
  rsp_t        rsp_q[$];
  int          checks = 0;
  int          passed = 0;

  function automatic rsp_t mk(input logic d, input logic p, input logic [31:0] a, input logic [127:0] x);
    rsp_t r;
    r.dmd = d; r.pf = p; r.addr = a; r.data = x;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Request monitor
  always @(negedge clk) begin
    if (!rst && ic_req_valid_o && ic_rdy) begin
      if (req_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ic_req: got addr %0h expected no request", ic_req_addr_o);
      end else begin
        logic [31:0] e;
        e = req_q.pop_front();
        chk("ic_req_addr", {96'd0, ic_req_addr_o}, {96'd0, e});
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (!rst && (dmd_rsp_valid_o || pf_rsp_valid_o)) begin
      if (rsp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got dmd=%0b pf=%0b expected none", dmd_rsp_valid_o, pf_rsp_valid_o);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("rsp_dmd_valid", {127'd0, dmd_rsp_valid_o}, {127'd0, e.dmd});
        chk("rsp_pf_valid", {127'd0, pf_rsp_valid_o}, {127'd0, e.pf});
        if (e.dmd) begin
          chk("rsp_dmd_addr", {96'd0, dmd_rsp_addr_o}, {96'd0, e.addr});
          chk("rsp_dmd_data", dmd_rsp_data_o, e.data);
        end
      end
    end
  end

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    mid();
    chk("reset_busy", {127'd0, busy_o}, 128'd0);
    chk("reset_ic_req_valid", {127'd0, ic_req_valid_o}, 128'd0);

    // Plain demand, response 3 cycles after issue
    cyc();
    dmd_v = 1'b1; dmd_a = 32'h8000_0000;
    req_q.push_back(32'h8000_0000);
    rsp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0000, 128'hDEAD));
    mid();
    chk("s1_dmd_ready", {127'd0, dmd_req_ready_o}, 128'd1);
    chk("s1_same_cycle_addr", {96'd0, ic_req_addr_o}, 128'h8000_0000);
    cyc(); dmd_v = 1'b0;
    mid();
    chk("s1_busy", {127'd0, busy_o}, 128'd1);
    cyc(); cyc();
    rsp_v = 1'b1; rsp_d = 128'hDEAD;
    cyc(); rsp_v = 1'b0;
    mid();
    chk("s1_idle_after", {127'd0, busy_o}, 128'd0);

    // Demand beats prefetch; prefetch goes in the IDLE cycle after the demand response
    cyc();
    dmd_v = 1'b1; dmd_a = 32'h8000_0040;
    pf_v = 1'b1;  pf_a = 32'h8000_0080;
    req_q.push_back(32'h8000_0040);
    rsp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0040, 128'h1111));
    mid();
    chk("s2_pf_not_ready", {127'd0, pf_req_ready_o}, 128'd0);
    cyc(); dmd_v = 1'b0;
    mid();
    chk("s2_pf_blocked", {127'd0, pf_req_ready_o}, 128'd0);
    chk("s2_no_req_in_wait", {127'd0, ic_req_valid_o}, 128'd0);
    cyc(); rsp_v = 1'b1; rsp_d = 128'h1111;
    cyc(); rsp_v = 1'b0;
    req_q.push_back(32'h8000_0080);
    rsp_q.push_back(mk(1'b0, 1'b1, 32'h0, 128'h0));
    mid();
    chk("s2_pf_issued", {127'd0, pf_req_ready_o}, 128'd1);
    cyc(); pf_v = 1'b0;
    cyc(); rsp_v = 1'b1; rsp_d = 128'h2222;
    cyc(); rsp_v = 1'b0;

    // Demand merges into an in-flight prefetch of the same line
    pf_v = 1'b1; pf_a = 32'h8000_0100;
    req_q.push_back(32'h8000_0100);
    cyc(); pf_v = 1'b0;
    dmd_v = 1'b1; dmd_a = 32'h8000_0108;
    rsp_q.push_back(mk(1'b1, 1'b1, 32'h8000_0108, 128'h3333));
    mid();
    chk("s3_merge_ready", {127'd0, dmd_req_ready_o}, 128'd1);
    chk("s3_merge_no_req", {127'd0, ic_req_valid_o}, 128'd0);
    cyc(); dmd_v = 1'b0;
    cyc(); rsp_v = 1'b1; rsp_d = 128'h3333;
    cyc(); rsp_v = 1'b0;

    // Prefetch of the line a demand just completed is dropped
    dmd_v = 1'b1; dmd_a = 32'h8000_0200;
    req_q.push_back(32'h8000_0200);
    rsp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0200, 128'h5555));
    cyc(); dmd_v = 1'b0;
    rsp_v = 1'b1; rsp_d = 128'h5555;
    cyc(); rsp_v = 1'b0;
    pf_v = 1'b1; pf_a = 32'h8000_0220;
    mid();
    chk("s4_drop_ready", {127'd0, pf_req_ready_o}, 128'd1);
    chk("s4_drop_no_req", {127'd0, ic_req_valid_o}, 128'd0);
    cyc(); pf_v = 1'b0;
    mid();
    chk("s4_stays_idle", {127'd0, busy_o}, 128'd0);

    // Flush in WAIT_RSP, response two cycles later is drained
    cyc();
    dmd_v = 1'b1; dmd_a = 32'h8000_0300;
    req_q.push_back(32'h8000_0300);
    cyc();
    dmd_a = 32'h9000_0000; flush = 1'b1;
    mid();
    chk("s5_flush_no_ready", {127'd0, dmd_req_ready_o}, 128'd0);
    chk("s5_flush_no_req", {127'd0, ic_req_valid_o}, 128'd0);
    cyc(); flush = 1'b0;
    mid();
    chk("s5_drain_busy", {127'd0, busy_o}, 128'd1);
    chk("s5_drain_hold", {127'd0, dmd_req_ready_o}, 128'd0);
    cyc(); rsp_v = 1'b1; rsp_d = 128'hBAD;
    mid();
    chk("s5_drain_rsp_hold", {127'd0, dmd_req_ready_o}, 128'd0);
    cyc(); rsp_v = 1'b0;
    req_q.push_back(32'h9000_0000);
    rsp_q.push_back(mk(1'b1, 1'b0, 32'h9000_0000, 128'h6666));
    mid();
    chk("s5_issue_after_drain", {127'd0, dmd_req_ready_o}, 128'd1);
    cyc(); dmd_v = 1'b0;
    rsp_v = 1'b1; rsp_d = 128'h6666;
    cyc(); rsp_v = 1'b0;

    // Flush coincident with the response
    dmd_v = 1'b1; dmd_a = 32'h8000_0400;
    req_q.push_back(32'h8000_0400);
    cyc();
    dmd_a = 32'hA000_0000;
    mid();
    chk("s6_wait_no_ready", {127'd0, dmd_req_ready_o}, 128'd0);
    cyc(); flush = 1'b1; rsp_v = 1'b1; rsp_d = 128'h7777;
    mid();
    chk("s6_flush_no_req", {127'd0, ic_req_valid_o}, 128'd0);
    cyc(); flush = 1'b0; rsp_v = 1'b0;
    req_q.push_back(32'hA000_0000);
    rsp_q.push_back(mk(1'b1, 1'b0, 32'hA000_0000, 128'h8888));
    mid();
    chk("s6_idle_next", {127'd0, busy_o}, 128'd0);
    chk("s6_pending_issues", {127'd0, dmd_req_ready_o}, 128'd1);
    cyc(); dmd_v = 1'b0;
    rsp_v = 1'b1; rsp_d = 128'h8888;
    cyc(); rsp_v = 1'b0;
    cyc();
    mid();
    chk("req_queue_empty", 128'(req_q.size()), 128'd0);
    chk("rsp_queue_empty", 128'(rsp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
